// File: rtl/adc3wire_pkg.sv
// rtl/adc3wire_pkg.sv - shared constants, frame field positions and FSM state type for the 3-wire config slave
// Purpose: frame geometry and the receiver state enum used by adc3wire_slave.
// Ports: none (package).
package adc3wire_pkg;

    localparam int FRAME_BITS = 32;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 16;
    localparam int HEADER_W   = 12;

    // Frame layout, MSB first on the wire: {header, addr, data}
    localparam int HDR_MSB  = 31;
    localparam int HDR_LSB  = 20;
    localparam int ADDR_MSB = 19;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/adc3wire_sync.sv
// rtl/adc3wire_sync.sv - N-bit two-flop synchroniser with per-bit reset value
// Purpose: bring asynchronous pins into the clk domain.
// Ports:
//   clk    in  1      destination clock
//   rst_n  in  1      asynchronous active-low reset
//   d      in  WIDTH  asynchronous inputs
//   q      out WIDTH  synchronised outputs (second flop)
module adc3wire_sync #(
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc3wire_slave.sv
// rtl/adc3wire_slave.sv - 3-wire (strobe/sclk/data) configuration target with 16x16 register bank
// Purpose: oversample the 3-wire pins, deserialise 32-bit {header, addr, data} frames and
//          commit frames with a good header and exactly 32 bits into the register bank.
// Ports:
//   wb_clk_i         in  1   system clock
//   wb_rst_n_i       in  1   asynchronous active-low reset
//   adc3wire_clk     in  1   serial clock (async)
//   adc3wire_data    in  1   serial data (async)
//   adc3wire_strobe  in  1   frame strobe (async), polarity from STROBE_ACTIVE_LOW
//   rd_addr          in  4   bank read address
//   rd_data          out 16  combinational bank[rd_addr]
//   wr_pulse         out 1   one-cycle pulse per committed frame
//   wr_addr          out 4   address of last committed frame
//   wr_data          out 16  data of last committed frame
//   frame_err        out 1   one-cycle pulse per rejected frame
//   busy             out 1   high while shifting a frame
import adc3wire_pkg::*;

module adc3wire_slave #(
    parameter bit                  STROBE_ACTIVE_LOW = 1'b1,
    parameter logic [DATA_W-1:0]   REG_RESET         = 16'h0000,
    parameter logic [HEADER_W-1:0] HEADER            = 12'h001
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              adc3wire_clk,
    input  logic              adc3wire_data,
    input  logic              adc3wire_strobe,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic              busy
);

    localparam logic       STROBE_IDLE = STROBE_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [5:0] CNT_FULL    = 6'(FRAME_BITS);
    localparam logic [5:0] CNT_SAT     = 6'(FRAME_BITS + 1);

    // pins_sync = {strobe, sclk, data}
    logic [2:0] pins_sync;

    adc3wire_sync #(
        .WIDTH     (3),
        .RESET_VAL ({STROBE_IDLE, 2'b00})
    ) u_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .d     ({adc3wire_strobe, adc3wire_clk, adc3wire_data}),
        .q     (pins_sync)
    );

    logic strobe_sync, sclk_sync, data_sync;
    logic strobe_hist, sclk_hist;

    assign strobe_sync = pins_sync[2];
    assign sclk_sync   = pins_sync[1];
    assign data_sync   = pins_sync[0];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            strobe_hist <= STROBE_IDLE;
            sclk_hist   <= 1'b0;
        end else begin
            strobe_hist <= strobe_sync;
            sclk_hist   <= sclk_sync;
        end
    end

    logic sclk_rise, strobe_act, strobe_act_hist, strobe_end;

    assign sclk_rise       = sclk_sync & ~sclk_hist;
    assign strobe_act      = STROBE_ACTIVE_LOW ? ~strobe_sync : strobe_sync;
    assign strobe_act_hist = STROBE_ACTIVE_LOW ? ~strobe_hist : strobe_hist;
    assign strobe_end      = strobe_act_hist & ~strobe_act;

    state_t                  state, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [5:0]              bit_cnt, bit_cnt_d;
    logic                    commit, reject;
    logic [DATA_W-1:0]       bank [2**ADDR_W];

    always_comb begin
        state_d   = state;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt;
        commit    = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE: begin
                if (strobe_act) begin
                    state_d   = SHIFT;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                // strobe_end takes priority so a coincident sclk edge is dropped
                if (strobe_end) begin
                    state_d = IDLE;
                    if (bit_cnt == CNT_FULL && shift_q[HDR_MSB:HDR_LSB] == HEADER) begin
                        commit = 1'b1;
                    end else if (bit_cnt != '0) begin
                        reject = 1'b1;
                    end
                end else if (sclk_rise && strobe_act) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], data_sync};
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt_d = bit_cnt + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < 2**ADDR_W; i++) begin
                bank[i] <= REG_RESET;
            end
        end else begin
            state     <= state_d;
            shift_q   <= shift_d;
            bit_cnt   <= bit_cnt_d;
            wr_pulse  <= commit;
            frame_err <= reject;
            if (commit) begin
                bank[shift_q[ADDR_MSB:ADDR_LSB]] <= shift_q[DATA_MSB:DATA_LSB];
                wr_addr <= shift_q[ADDR_MSB:ADDR_LSB];
                wr_data <= shift_q[DATA_MSB:DATA_LSB];
            end
        end
    end

    assign rd_data = bank[rd_addr];
    assign busy    = (state == SHIFT);

endmodule

// File: tb/tb_adc3wire_slave.sv
// tb/tb_adc3wire_slave.sv - scoreboard bench for adc3wire_slave (both strobe polarities)
module tb_adc3wire_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk, sdata, s0, s1;
    logic [3:0]  rd_addr0, rd_addr1;
    logic [15:0] rd_data0, rd_data1, wr_data0, wr_data1;
    logic [3:0]  wr_addr0, wr_addr1;
    logic        wr_pulse0, wr_pulse1, frame_err0, frame_err1, busy0, busy1;

    always #5 clk = ~clk;

    adc3wire_slave #(.STROBE_ACTIVE_LOW(1'b1)) dut0 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .adc3wire_clk(sclk), .adc3wire_data(sdata),
        .adc3wire_strobe(s0), .rd_addr(rd_addr0), .rd_data(rd_data0), .wr_pulse(wr_pulse0),
        .wr_addr(wr_addr0), .wr_data(wr_data0), .frame_err(frame_err0), .busy(busy0));

    adc3wire_slave #(.STROBE_ACTIVE_LOW(1'b0)) dut1 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .adc3wire_clk(sclk), .adc3wire_data(sdata),
        .adc3wire_strobe(s1), .rd_addr(rd_addr1), .rd_data(rd_data1), .wr_pulse(wr_pulse1),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .frame_err(frame_err1), .busy(busy1));

    typedef struct {
        bit          is_err;
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        q0[$], q1[$];
    logic [15:0] model0 [16];
    logic [15:0] model1 [16];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] mk(input logic [11:0] h, input logic [3:0] a, input logic [15:0] d);
        return {h, a, d};
    endfunction

    task automatic expect_commit(input int which, input logic [3:0] a, input logic [15:0] d);
        exp_t e;
        e.is_err = 1'b0; e.addr = a; e.data = d;
        if (which == 0) begin q0.push_back(e); model0[a] = d; end
        else begin q1.push_back(e); model1[a] = d; end
    endtask

    task automatic expect_err(input int which);
        exp_t e;
        e.is_err = 1'b1; e.addr = '0; e.data = '0;
        if (which == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon(input int which, input logic p, input logic er,
                       input logic [3:0] a, input logic [15:0] d);
        exp_t e;
        bit   have;
        string tag;
        tag = (which == 0) ? "dut0" : "dut1";
        if (p || er) begin
            have = 1'b0;
            if (which == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (which == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL %s unexpected_event: got pulse=%0b err=%0b expected none", tag, p, er);
            end else begin
                chk({tag, " evt_pulse"}, 32'(p), 32'(!e.is_err));
                chk({tag, " evt_err"}, 32'(er), 32'(e.is_err));
                if (!e.is_err) begin
                    chk({tag, " wr_addr"}, 32'(a), 32'(e.addr));
                    chk({tag, " wr_data"}, 32'(d), 32'(e.data));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, wr_pulse0, frame_err0, wr_addr0, wr_data0);
        mon(1, wr_pulse1, frame_err1, wr_addr1, wr_data1);
    end

    task automatic strobe_set(input int which, input bit active);
        if (which == 0) s0 = ~active;
        else s1 = active;
    endtask

    task automatic shift_bit(input logic b);
        sdata = b;
        sclk  = 1'b0;
        wait_cyc(8);
        sclk  = 1'b1;
        wait_cyc(8);
        sclk  = 1'b0;
    endtask

    task automatic send_frame(input int which, input logic [32:0] bits, input int n, input int gap);
        strobe_set(which, 1'b1);
        wait_cyc(4);
        for (int i = n - 1; i >= 0; i--) shift_bit(bits[i]);
        wait_cyc(4);
        strobe_set(which, 1'b0);
        wait_cyc(gap);
    endtask

    task automatic check_bank(input int which, input logic [3:0] a);
        @(negedge clk);
        if (which == 0) rd_addr0 = a; else rd_addr1 = a;
        #1;
        if (which == 0) chk($sformatf("dut0 bank[%0d]", a), 32'(rd_data0), 32'(model0[a]));
        else            chk($sformatf("dut1 bank[%0d]", a), 32'(rd_data1), 32'(model1[a]));
    endtask

    initial begin
        logic [31:0] f;
        rst_n = 1'b0; sclk = 1'b0; sdata = 1'b0; s0 = 1'b1; s1 = 1'b0;
        rd_addr0 = '0; rd_addr1 = '0;
        for (int i = 0; i < 16; i++) begin model0[i] = 16'h0000; model1[i] = 16'h0000; end
        wait_cyc(3);
        chk("reset busy0", 32'(busy0), 32'd0);
        chk("reset busy1", 32'(busy1), 32'd0);
        chk("reset wr_pulse0", 32'(wr_pulse0), 32'd0);
        chk("reset frame_err0", 32'(frame_err0), 32'd0);
        chk("reset wr_addr0", 32'(wr_addr0), 32'd0);
        chk("reset wr_data0", 32'(wr_data0), 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);
        for (int i = 0; i < 16; i++) check_bank(0, 4'(i));

        // valid frame
        expect_commit(0, 4'h5, 16'hA5C3);
        send_frame(0, {1'b0, mk(12'h001, 4'h5, 16'hA5C3)}, 32, 12);
        check_bank(0, 4'h5);

        // bad header
        expect_err(0);
        send_frame(0, {1'b0, mk(12'h003, 4'h7, 16'hBEEF)}, 32, 12);
        check_bank(0, 4'h7);

        // 31 bits, 33 bits, zero clocks
        f = mk(12'h001, 4'h3, 16'h1111);
        expect_err(0);
        send_frame(0, {2'b00, f[31:1]}, 31, 12);
        expect_err(0);
        send_frame(0, {f, 1'b1}, 33, 12);
        check_bank(0, 4'h3);
        send_frame(0, 33'd0, 0, 12);

        // reset mid-frame
        strobe_set(0, 1'b1);
        wait_cyc(4);
        f = mk(12'h001, 4'h6, 16'h5555);
        for (int i = 31; i > 21; i--) shift_bit(f[i]);
        chk("busy0 mid-frame", 32'(busy0), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("busy0 async reset", 32'(busy0), 32'd0);
        s0 = 1'b1;
        for (int i = 0; i < 16; i++) begin model0[i] = 16'h0000; model1[i] = 16'h0000; end
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);
        expect_commit(0, 4'h2, 16'h1234);
        send_frame(0, {1'b0, mk(12'h001, 4'h2, 16'h1234)}, 32, 12);
        for (int i = 0; i < 16; i++) check_bank(0, 4'(i));

        // edge collision: 32nd sclk rise coincides with strobe end
        f = mk(12'h001, 4'h9, 16'h0F0F);
        expect_err(0);
        strobe_set(0, 1'b1);
        wait_cyc(4);
        for (int i = 31; i > 0; i--) shift_bit(f[i]);
        sdata = f[0];
        wait_cyc(8);
        sclk = 1'b1;
        s0   = 1'b1;
        wait_cyc(8);
        sclk = 1'b0;
        wait_cyc(12);
        check_bank(0, 4'h9);

        // back-to-back on active-high strobe, 1-cycle gap
        expect_commit(1, 4'h1, 16'hFFFF);
        send_frame(1, {1'b0, mk(12'h001, 4'h1, 16'hFFFF)}, 32, 1);
        expect_commit(1, 4'h1, 16'h0001);
        send_frame(1, {1'b0, mk(12'h001, 4'h1, 16'h0001)}, 32, 12);
        check_bank(1, 4'h1);
        check_bank(1, 4'h0);

        wait_cyc(10);
        chk("dut0 pending expected events", 32'(q0.size()), 32'd0);
        chk("dut1 pending expected events", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
